pb_conditioner: RTL
===================

Name: pb_conditioner

Overview:
Input-side stage for the Tug-of-War game. It sits between the raw pbr/pbl push-buttons and the round logic (synchronizer/opp/pbl/scorer path). It synchronizes and debounces both buttons, detects press edges and arbitrates one press result per armed round: left, right or tie. It emits a single-cycle result strobe with a held winner/tie flag, replacing direct raw-button use downstream.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to change a debounced level (>=2)
TIE_WINDOW, 2, cycles after the first press during which an opposing press still counts as a tie (>=1)

Ports:
clk  input  1  system clock (divided game clock)
rst  input  1  asynchronous, active-high reset
pbr_raw  input  1  raw right push-button, asynchronous, active-high
pbl_raw  input  1  raw left push-button, asynchronous, active-high
arm  input  1  round controller enable; presses accepted only while high
pbr_db  output  1  debounced right button level
pbl_db  output  1  debounced left button level
valid  output  1  one-cycle strobe: a result is available
right  output  1  winner side, 1=right 0=left; meaningful when tie=0
tie  output  1  result was a tie
busy  output  1  high in WAIT, REPORT or HOLD

Behaviour:
- Reset is asynchronous and active-high. All flops clear: sync chains, debounce counters, pbr_db, pbl_db, delayed copies, FSM=IDLE, valid=0, right=0, tie=0, busy=0.
- Synchronizer: each raw input passes through 2 flops. s_x is the second flop.
- Debounce, per side:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If s_x == x_db, the counter clears.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 with s_x still differing, x_db toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes x_db.
  - Raw change to x_db change = 2 + DEBOUNCE_CYCLES edges.
- Press detect: press_x = x_db & ~x_db_d, where x_db_d is x_db delayed by 1 cycle. It is high exactly 1 cycle per debounced rising edge. Releases generate nothing.
- FSM states are IDLE, WAIT, REPORT, HOLD.
  - IDLE:
    - arm=0: all presses are ignored.
    - arm=1, press_l and press_r in the same cycle: go to REPORT, load tie=1, right=0.
    - arm=1, exactly one press: go to WAIT, latch the side, clear the window counter.
  - WAIT (checked in this priority order):
    - arm=0: go to IDLE, no valid, right/tie unchanged.
    - Opposing press: go to REPORT with tie=1, right=0.
    - Window counter == TIE_WINDOW-1: go to REPORT with tie=0 and right=latched side.
    - Otherwise: increment the window counter.
    - A repeat press on the same side is ignored.
  - REPORT: valid=1 for exactly this cycle (Moore output), then go to HOLD.
  - HOLD: ignore all presses. Go to IDLE when arm=0. If arm stays high, stay in HOLD (one result per round).
- right/tie are registered. They change only on entry to REPORT and hold until the next REPORT or reset.
- Timing:
  - Single press pulse seen in IDLE at edge t: WAIT occupies t+1..t+TIE_WINDOW, valid is high at t+TIE_WINDOW+1.
  - Simultaneous press at edge t: valid is high at t+1.
- busy = (state != IDLE).
- Reset mid-WAIT or mid-REPORT drops any pending result immediately, with no valid.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, TIE_WINDOW=2.)
1. Reset then idle. Hold rst high with pbr_raw=1 → all outputs 0. After release, pbr_db rises 6 edges later and busy stays 0 because arm=0.
2. Single left press. arm=1, pbl_raw high for 10 cycles → pbl_db rises after 6 edges. valid pulses 1 cycle, 3 cycles after the press pulse, with right=0, tie=0. busy=1 from the press until arm drops.
3. Near-simultaneous press. arm=1, pbr_raw rises, pbl_raw rises 1 cycle later → exactly one valid with tie=1, right=0. With a 3-cycle offset → valid with right=1, tie=0.
4. Glitch rejection. arm=1, pbr_raw pulses high for 3 cycles, repeated with 3-cycle gaps → pbr_db never rises, valid never asserts.
5. One result per round. After a right win keep arm=1 and press left repeatedly → no further valid, right stays 1. Drop arm 1 cycle, re-arm, press left → valid with right=0.
6. Abort and async reset. Press right, drop arm during WAIT → no valid, right/tie unchanged. Repeat and assert rst mid-WAIT between clock edges → busy=0 and right=0 immediately, no valid afterwards.

Source files
------------

// File: rtl/pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
//
// Input stage for the Tug-of-War game. It synchronizes and debounces the raw
// left/right push-buttons, turns debounced rising edges into one-cycle press
// pulses, and arbitrates a single result per armed round: left win, right win
// or tie. A result is announced with a one-cycle valid strobe; the winner and
// tie flags are registered and held until the next result or reset.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to change
//                     a debounced level (>= 2)
//   TIE_WINDOW      : cycles after the first press in which an opposing press
//                     still counts as a tie (>= 1)
//
// Ports
//   clk      in   system clock (divided game clock)
//   rst      in   asynchronous, active-high reset
//   pbr_raw  in   raw right push-button (asynchronous, active-high)
//   pbl_raw  in   raw left push-button (asynchronous, active-high)
//   arm      in   round enable; presses are accepted only while high
//   pbr_db   out  debounced right button level
//   pbl_db   out  debounced left button level
//   valid    out  one-cycle strobe: a result is available
//   right    out  winner side, 1=right 0=left (meaningful when tie=0)
//   tie      out  result was a tie
//   busy     out  a round is in progress or its result is being held
// -----------------------------------------------------------------------------
module pb_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIE_WINDOW      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pbr_raw,
    input  logic pbl_raw,
    input  logic arm,
    output logic pbr_db,
    output logic pbl_db,
    output logic valid,
    output logic right,
    output logic tie,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Window counter only has to reach TIE_WINDOW-1; keep at least one bit so
    // TIE_WINDOW=1 still yields a legal vector.
    localparam int WW = (TIE_WINDOW > 1) ? $clog2(TIE_WINDOW) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(TIE_WINDOW - 1);

    // Side index: 0 = right, 1 = left.
    logic [1:0] w_raw;
    logic [1:0] w_db;
    logic [1:0] w_press;

    assign w_raw = {pbl_raw, pbr_raw};

    // -------------------------------------------------------------------------
    // Per-side synchronizer, debouncer and press-edge detector.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic          r_sync1;
            logic          r_sync2;
            logic          r_db;
            logic          r_db_d;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    // The counter measures how long the synchronized input has
                    // disagreed with the debounced level; any agreement restarts it.
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_db  <= ~r_db;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign w_db[gi]    = r_db;
            // High for exactly one cycle after each debounced rising edge.
            assign w_press[gi] = r_db & ~r_db_d;
        end
    endgenerate

    logic w_press_r;
    logic w_press_l;

    assign w_press_r = w_press[0];
    assign w_press_l = w_press[1];
    assign pbr_db    = w_db[0];
    assign pbl_db    = w_db[1];

    // -------------------------------------------------------------------------
    // Round arbitration FSM.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPORT,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_right;
    logic          w_right_next;
    logic          r_tie;
    logic          w_tie_next;
    logic          r_side;       // side of the first press, 1 = right
    logic          w_side_next;
    logic [WW-1:0] r_win;        // cycles spent waiting for an opposing press
    logic [WW-1:0] w_win_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_right <= 1'b0;
            r_tie   <= 1'b0;
            r_side  <= 1'b0;
            r_win   <= '0;
        end else begin
            r_state <= w_state_next;
            r_right <= w_right_next;
            r_tie   <= w_tie_next;
            r_side  <= w_side_next;
            r_win   <= w_win_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_right_next = r_right;
        w_tie_next   = r_tie;
        w_side_next  = r_side;
        w_win_next   = r_win;

        unique case (r_state)
            S_IDLE: begin
                if (arm) begin
                    if (w_press_r && w_press_l) begin
                        w_state_next = S_REPORT;
                        w_tie_next   = 1'b1;
                        w_right_next = 1'b0;
                    end else if (w_press_r || w_press_l) begin
                        w_state_next = S_WAIT;
                        w_side_next  = w_press_r;
                        w_win_next   = '0;
                    end
                end
            end

            S_WAIT: begin
                // Abort beats everything; an opposing press beats the window
                // expiring in the same cycle. Repeat presses on the latched
                // side fall through and are ignored.
                if (!arm) begin
                    w_state_next = S_IDLE;
                end else if (r_side ? w_press_l : w_press_r) begin
                    w_state_next = S_REPORT;
                    w_tie_next   = 1'b1;
                    w_right_next = 1'b0;
                end else if (r_win == WIN_LAST) begin
                    w_state_next = S_REPORT;
                    w_tie_next   = 1'b0;
                    w_right_next = r_side;
                end else begin
                    w_win_next = r_win + WW'(1);
                end
            end

            S_REPORT: begin
                w_state_next = S_HOLD;
            end

            S_HOLD: begin
                // One result per round: wait for the controller to disarm.
                if (!arm) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign valid = (r_state == S_REPORT);
    assign busy  = (r_state != S_IDLE);
    assign right = r_right;
    assign tie   = r_tie;

endmodule
